// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - bank of WIDTH JK bits with change pulse and change-event counter
// Optional feature: define JK_REG_BANK_CHG_CNT_EN to build the saturating chg_cnt counter;
// otherwise chg_cnt is tied to zero and cnt_clr is ignored.
module jk_reg_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic [WIDTH-1:0] w_q_next;
  logic             w_chg;

  // Next-state selection: clr beats load beats JK update beats hold.
  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = '0;
    end else if (load) begin
      w_q_next = d;
    end else if (en) begin
      // Per bit: 00 hold, 01 clear, 10 set, 11 invert.
      w_q_next = (r_q & ~k) | (~r_q & j);
    end
  end

  assign w_chg = (w_q_next != r_q);

  // Bank state and change pulse share one edge; reset forces both low at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_chg;
    end
  end

  assign q       = r_q;
  assign changed = r_changed;

`ifdef JK_REG_BANK_CHG_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating event counter; cnt_clr wins over a simultaneous change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_chg && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign chg_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign chg_cnt          = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - scoreboard testbench for jk_reg_bank
module tb_jk_reg_bank;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             chg;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic             changed;
  logic [CNT_W-1:0] chg_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_q;
  int               m_cnt;
  exp_t             sb_q[$];

  jk_reg_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .j       (j),
    .k       (k),
    .clr     (clr),
    .load    (load),
    .d       (d),
    .cnt_clr (cnt_clr),
    .q       (q),
    .changed (changed),
    .chg_cnt (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs, push the model's prediction, then compare after the edge.
  task automatic step(input string tag, input logic i_en, input logic [WIDTH-1:0] i_j,
                      input logic [WIDTH-1:0] i_k, input logic i_clr, input logic i_load,
                      input logic [WIDTH-1:0] i_d, input logic i_cnt_clr);
    logic [WIDTH-1:0] nq;
    exp_t e;
    exp_t got;
    en = i_en; j = i_j; k = i_k; clr = i_clr; load = i_load; d = i_d; cnt_clr = i_cnt_clr;
    nq = m_q;
    if (i_clr) nq = '0;
    else if (i_load) nq = i_d;
    else if (i_en) begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({i_j[b], i_k[b]})
          2'b01:   nq[b] = 1'b0;
          2'b10:   nq[b] = 1'b1;
          2'b11:   nq[b] = ~m_q[b];
          default: nq[b] = m_q[b];
        endcase
      end
    end
    e.q   = nq;
    e.chg = (nq != m_q);
`ifdef JK_REG_BANK_CHG_CNT_EN
    if (i_cnt_clr) m_cnt = 0;
    else if (e.chg && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`else
    m_cnt = 0;
`endif
    e.cnt = m_cnt[CNT_W-1:0];
    m_q   = nq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq({tag, ".q"},   {24'd0, q},       {24'd0, got.q});
    check_eq({tag, ".chg"}, {31'd0, changed}, {31'd0, got.chg});
    check_eq({tag, ".cnt"}, {28'd0, chg_cnt}, {28'd0, got.cnt});
  endtask

  initial begin
    reset = 1'b1; en = 0; j = '0; k = '0; clr = 0; load = 0; d = '0; cnt_clr = 0;
    m_q = '0; m_cnt = 0;
    #1;
    check_eq("rst.q",   {24'd0, q},       32'd0);
    check_eq("rst.chg", {31'd0, changed}, 32'd0);
    check_eq("rst.cnt", {28'd0, chg_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Set/clear, then invert all.
    step("jk_setclr", 1, 8'hF0, 8'h0F, 0, 0, 8'h00, 0);
    step("jk_inv",    1, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);

    // Priority of clr over load, load over en, hold ignoring j/k.
    step("load_a5",   0, 8'h00, 8'h00, 0, 1, 8'hA5, 0);
    step("clr_pri",   1, 8'hFF, 8'h00, 1, 1, 8'h3C, 0);
    step("load_pri",  1, 8'hFF, 8'hFF, 0, 1, 8'h3C, 0);
    step("hold",      0, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
    step("load_same", 1, 8'hFF, 8'hFF, 0, 1, 8'h3C, 0);
    step("jk_same",   1, 8'h3C, 8'hC3, 0, 0, 8'h00, 0);
    step("clr_q",     0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    step("clr_same",  0, 8'h00, 8'h00, 1, 0, 8'h00, 0);

    // Counter clear alone, then saturation with 20 toggles.
    step("cntclr",    0, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step("sat", 1, 8'h01, 8'h01, 0, 0, 8'h00, 0);

    // Clear overrides a simultaneous change event at count 7.
    step("cntclr2",   0, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    for (int i = 0; i < 7; i++) step("to7", 1, 8'h01, 8'h01, 0, 0, 8'h00, 0);
    step("cntclr_tog", 1, 8'h01, 8'h01, 0, 0, 8'h00, 1);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 8'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset between edges with q=FF and a pending update.
    step("load_ff", 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0);
    en = 1; j = 8'h00; k = 8'hFF;
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst.q",   {24'd0, q},       32'd0);
    check_eq("arst.chg", {31'd0, changed}, 32'd0);
    check_eq("arst.cnt", {28'd0, chg_cnt}, 32'd0);
    m_q = '0; m_cnt = 0;
    #1;
    reset = 1'b0;
    step("post_rst",  0, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
    step("post_rst2", 1, 8'h81, 8'h00, 0, 0, 8'h00, 0);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent JK bits.
REQ-002 SHALL have parameter CNT_W, default 16: width of change-event counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1: JK update enable.
REQ-006 SHALL have port j  input  WIDTH: per-bit J inputs.
REQ-007 SHALL have port k  input  WIDTH: per-bit K inputs.
REQ-008 SHALL have port clr  input  1: synchronous clear of q.
REQ-009 SHALL have port load  input  1: synchronous parallel load.
REQ-010 SHALL have port d  input  WIDTH: parallel load data.
REQ-011 SHALL have port cnt_clr  input  1: synchronous clear of chg_cnt.
REQ-012 SHALL have port q  output  WIDTH: registered bank state.
REQ-013 SHALL have port changed  output  1: registered pulse, high for one cycle after any q bit changed.
REQ-014 SHALL have port chg_cnt  output  CNT_W: saturating count of change events.

Function
REQ-015 SHALL resolve each edge by priority: reset > clr > load > en (JK) > hold.
REQ-016 clr=1 SHALL set q to all zeros on the next edge regardless of load, en, j, k.
REQ-017 load=1 with clr=0 SHALL set q to d on the next edge regardless of en.
REQ-018 en=1, clr=0, load=0 SHALL update each bit i independently: {j[i],k[i]} 00 hold, 01 clear, 10 set, 11 invert.
REQ-019 en=0, clr=0, load=0 SHALL hold q unchanged, ignoring j and k.
REQ-020 Latency from qualifying inputs to q SHALL be exactly one clock edge; no combinational path from inputs to q.
REQ-021 changed SHALL be registered on the same edge as q, high iff the new q differs from the previous q in at least one bit.
REQ-022 A clr, load or JK update yielding identical q SHALL leave changed low.
REQ-023 chg_cnt SHALL increment by 1 on each edge where changed is set high, one increment per edge regardless of how many bits changed.
REQ-024 chg_cnt SHALL saturate at 2^CNT_W-1 and hold; no wrap-around.
REQ-025 cnt_clr=1 SHALL zero chg_cnt on the next edge, overriding a simultaneous change event (result 0, not 1).
REQ-026 cnt_clr SHALL NOT affect q or changed.

Reset
REQ-027 Assertion of reset SHALL immediately, without a clock edge, force q=0, changed=0, chg_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending update; first update after deassertion occurs on the first posedge with reset low.
REQ-029 Transition of q from pre-reset value to 0 caused by reset SHALL NOT count as a change event.

Configuration
REQ-030 Macro JK_REG_BANK_CHG_CNT_EN SHALL compile in the chg_cnt counter logic.
REQ-031 With JK_REG_BANK_CHG_CNT_EN defined, chg_cnt SHALL behave per REQ-023..REQ-025.
REQ-032 Without it, chg_cnt port SHALL remain present and be tied to constant 0, cnt_clr ignored; q and changed unaffected.

Verification (WIDTH=8, CNT_W=4, macro defined unless stated)
REQ-033 Reset, then en=1, j=8'hF0, k=8'h0F -> q=8'hF0, changed=1, chg_cnt=1; next edge j=k=8'hFF -> q=8'h0F, chg_cnt=2.
REQ-034 q=8'hA5, clr=1, load=1, d=8'h3C, en=1 -> q=8'h00; then clr=0, load=1, d=8'h3C -> q=8'h3C; then load=0, en=0, j=k=8'hFF -> q holds 8'h3C, changed=0.
REQ-035 q=8'h00, en=1, j=k=8'h01 for 20 edges -> q toggles bit0 each edge, chg_cnt reaches 15 and holds at 15.
REQ-036 chg_cnt=7, cnt_clr=1 simultaneous with toggle -> chg_cnt=0, q updated, changed=1.
REQ-037 Reset asserted between edges with q=8'hFF -> q=0, changed=0, chg_cnt=0 before next posedge; chg_cnt remains 0 after first edge with no change.
REQ-038 Macro undefined: repeat REQ-033 -> q identical, chg_cnt constantly 0.
